simon_key_expand: RTL and testbench
===================================

Name: simon_key_expand

Overview:
- Key-schedule generator for Simon 32/64: word n=16, m=4 key words, T=32 rounds.
- Loads a 64-bit master key on start and produces the 32 round keys, one per cycle, into an internal register file.
- Raises key_done when all round keys are valid; the control FSM holds in its enc_gen/dec_gen states until key_done is high.
- The round datapath reads keys by index: ascending for encryption, descending for decryption.

Parameters:
- N, 16, word width in bits.
- M, 4, number of master key words.
- T, 32, number of rounds / round keys.
- AW, 5, read-address width, equal to clog2(T).

Ports:
- clk  input  1  system clock, rising edge.
- res_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle load strobe; samples key_in.
- key_in  input  64  master key: [15:0]=k0, [31:16]=k1, [47:32]=k2, [63:48]=k3.
- rd_addr  input  5  round-key index, 0..31.
- rd_key  output  16  round key at rd_addr; combinational read.
- busy  output  1  high while generating.
- key_done  output  1  level; high when k0..k31 are all valid.

Behaviour:
- Reset (res_n low, asynchronous):
  - State is IDLE; idx=0; busy=0; key_done=0.
  - Register file cleared to 0, so rd_key reads 0.
- States are IDLE, GEN and DONE.
- Loading on start:
  - start in any state, including GEN and DONE, writes k0..k3 from key_in.
  - It also sets idx=4, busy=1, key_done=0 and moves to GEN.
  - start has priority over everything else, so a restart mid-generation aborts the old schedule.
- Generation step, in GEN each cycle:
  - tmp = ror(k[idx-1],3) ^ k[idx-3]
  - tmp = tmp ^ ror(tmp,1)
  - k[idx] = 16'hFFFC ^ z0[idx-4] ^ k[idx-4] ^ tmp
  - idx increments by 1.
- Rotation is within 16 bits. z0[j] enters at bit 0 only.
- z0 is the 62-element sequence 11111010001001010110000111001101111101000100101011000011100110, with element 0 leftmost. Only j=0..27 are used, so there is no wrap.
- Keys k[idx-1..idx-4] come from a 4-word sliding window register. This avoids multi-port reads of the file.
- End of generation: when idx=31 is written, the state moves to DONE. On the next edge this gives busy=0 and key_done=1.
- Latency: with start sampled at edge E0, k31 is written at edge E28, and key_done is high after E28. That is 28 cycles from start to key_done.
- DONE holds key_done=1 and the register file until the next start or reset.
- Reads:
  - rd_key = file[rd_addr] combinationally, in any state.
  - Reading an index not yet generated returns a stale or zero value. This is legal but meaningless.
- Boundaries:
  - start asserted on consecutive cycles reloads each cycle, and the last strobe wins.
  - key_in is sampled only on the start cycle.
  - Asynchronous reset mid-GEN aborts immediately, and key_done stays 0 after release.

Decomposition:
- Package simon_pkg holds:
  - N, M, T;
  - C = 16'hFFFC;
  - Z0 as a 62-bit constant;
  - state encoding as one-hot localparams, IDLE=3'b001, GEN=3'b010, DONE=3'b100.
- Sub-module simon_key_round is combinational. It takes the 4-word window and the z bit and returns the next key.
- The main block holds the FSM, the idx counter, the window and the 32x16 register file.

Test Plan:
- Vector: key_in=64'h1918_1110_0908_0100, start one cycle -> rd_addr 0..3 read 0100, 0908, 1110, 1918; rd_addr 4 reads 71C3; key_done rises exactly 28 cycles after start; busy is high for those 28 cycles.
- Full schedule: the same key -> all 32 rd_key values match a software Simon 32/64 model; encrypting with those keys yields plaintext 6565_6877 -> ciphertext C69B_E9BB.
- Restart: second start with key 64'h0 at idx=15 -> key_done is delayed to 28 cycles after the second start; k4 = FFFC ^ 1 = FFFD.
- Reset mid-GEN: pull res_n low at idx=10, without waiting for a clock edge -> busy=0, key_done=0, rd_key=0 immediately; no key_done after release until a new start.
- Hold: after DONE, idle for 100 cycles, then sweep rd_addr 31..0 -> values unchanged; key_done stays 1.
- Back-to-back start on 3 cycles with keys A, B, C -> the schedule corresponds to C; key_done occurs 28 cycles after the last strobe.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants for the Simon 32/64 key schedule: word geometry, the
// round constant, the z0 sequence and the one-hot FSM state encoding.
package simon_pkg;

    localparam int N  = 16;   // word width
    localparam int M  = 4;    // master key words
    localparam int T  = 32;   // rounds / round keys
    localparam int AW = 5;    // round-key index width

    // Round constant: ~k ^ 3 is rewritten as k ^ 16'hFFFC.
    localparam logic [N-1:0] C = 16'hFFFC;

    // z0 sequence, element 0 is the leftmost (most significant) bit.
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    // One-hot FSM states.
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_GEN  = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b100;

    // Rotate right within one word.
    function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int r);
        ror = (x >> r) | (x << (N - r));
    endfunction

endpackage

// File: rtl/simon_key_round.sv
// Combinational Simon 32/64 key-schedule step: from the sliding window
// words k[i-1], k[i-3], k[i-4] and the z0 bit, produce k[i].
module simon_key_round
    import simon_pkg::*;
(
    input  logic [N-1:0] k_m1,
    input  logic [N-1:0] k_m3,
    input  logic [N-1:0] k_m4,
    input  logic         z_bit,
    output logic [N-1:0] k_next
);

    logic [N-1:0] tmp_a;
    logic [N-1:0] tmp_b;

    // Key mixing: z bit only touches bit 0.
    always_comb begin
        tmp_a  = ror(k_m1, 3) ^ k_m3;
        tmp_b  = tmp_a ^ ror(tmp_a, 1);
        k_next = C ^ k_m4 ^ tmp_b ^ {{(N-1){1'b0}}, z_bit};
    end

endmodule

// File: rtl/simon_key_expand.sv
// Simon 32/64 key expansion: loads a 64-bit master key on start, then
// produces one round key per cycle into a 32x16 register file that the
// round datapath reads combinationally by index.
module simon_key_expand
    import simon_pkg::*;
(
    input  logic            clk,
    input  logic            res_n,
    input  logic            start,
    input  logic [M*N-1:0]  key_in,
    input  logic [AW-1:0]   rd_addr,
    output logic [N-1:0]    rd_key,
    output logic            busy,
    output logic            key_done
);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    // win_q[3] = k[idx-1] ... win_q[0] = k[idx-4]
    logic [N-1:0]  win_q  [M];
    logic [N-1:0]  win_d  [M];
    logic [N-1:0]  file_q [T];
    logic [N-1:0]  file_d [T];

    logic [5:0]    z_pos;
    logic [61:0]   z_shift;
    logic          z_bit;
    logic [N-1:0]  k_next;

    // Select z0[idx-4]: shift the wanted element up to the MSB.
    always_comb begin
        z_pos   = {1'b0, idx_q} - 6'd4;
        z_shift = Z0 << z_pos;
        z_bit   = z_shift[61];
    end

    simon_key_round u_round (
        .k_m1   (win_q[3]),
        .k_m3   (win_q[1]),
        .k_m4   (win_q[0]),
        .z_bit  (z_bit),
        .k_next (k_next)
    );

    // State register plus datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            for (int i = 0; i < M; i++) win_q[i]  <= '0;
            for (int i = 0; i < T; i++) file_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < M; i++) win_q[i]  <= win_d[i];
            for (int i = 0; i < T; i++) file_q[i] <= file_d[i];
        end
    end

    // Next-state logic: start overrides everything, GEN ends after k31.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_GEN;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_GEN:  if (idx_q == AW'(T - 1)) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: load master key on start, otherwise write one key per GEN cycle.
    always_comb begin
        idx_d  = idx_q;
        win_d  = win_q;
        file_d = file_q;
        if (start) begin
            for (int i = 0; i < M; i++) begin
                win_d[i]  = key_in[i*N +: N];
                file_d[i] = key_in[i*N +: N];
            end
            idx_d = AW'(M);
        end else if (state_q == ST_GEN) begin
            file_d[idx_q] = k_next;
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = win_q[3];
            win_d[3] = k_next;
            if (idx_q != AW'(T - 1)) idx_d = idx_q + AW'(1);
        end
    end

    // Outputs decoded from state.
    always_comb begin
        busy     = (state_q == ST_GEN);
        key_done = (state_q == ST_DONE);
    end

    assign rd_key = file_q[rd_addr];

endmodule

// File: tb/tb_simon_key_expand.sv
// Directed testbench for simon_key_expand: known Simon 32/64 vectors,
// latency, restart, asynchronous reset, hold and back-to-back strobes.
module tb_simon_key_expand;

    logic        clk;
    logic        res_n;
    logic        start;
    logic [63:0] key_in;
    logic [4:0]  rd_addr;
    logic [15:0] rd_key;
    logic        busy;
    logic        key_done;

    int checks;
    int failures;

    logic [15:0] exp_k [32];
    logic [15:0] dut_k [32];

    localparam logic [63:0] KEY_STD = 64'h1918_1110_0908_0100;

    simon_key_expand dut (
        .clk      (clk),
        .res_n    (res_n),
        .start    (start),
        .key_in   (key_in),
        .rd_addr  (rd_addr),
        .rd_key   (rd_key),
        .busy     (busy),
        .key_done (key_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rotr(input logic [15:0] x, input int r);
        rotr = (x >> r) | (x << (16 - r));
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] x, input int r);
        rotl = (x << r) | (x >> (16 - r));
    endfunction

    // Reference Simon 32/64 key schedule (textbook form with ~k ^ 3).
    function automatic void model_keys(input logic [63:0] key);
        logic [61:0] z;
        logic [15:0] tmp;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        for (int i = 0; i < 4; i++) exp_k[i] = key[i*16 +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp = rotr(exp_k[i-1], 3) ^ exp_k[i-3];
            tmp = tmp ^ rotr(tmp, 1);
            exp_k[i] = ~exp_k[i-4] ^ tmp ^ {15'd0, z[61-(i-4)]} ^ 16'd3;
        end
    endfunction

    task automatic read_key(input int a, output logic [15:0] v);
        rd_addr = 5'(a);
        #1;
        v = rd_key;
    endtask

    task automatic apply_start(input logic [63:0] key);
        @(negedge clk);
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        start  = 1'b0;
        key_in = 64'hDEAD_BEEF_CAFE_F00D;
    endtask

    // Counts edges from the current negedge until key_done, bounded.
    task automatic wait_done(output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (!key_done && cycles < 60) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        logic [15:0] v;
        res_n = 1'b0; start = 1'b0; key_in = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (key_done !== 1'b0) begin
            failures++; $display("FAIL reset_key_done got=%b exp=0", key_done);
        end
        foreach (exp_k[a]) begin
            read_key(a, v);
            checks++;
            if (v !== 16'h0) begin
                failures++; $display("FAIL reset_rd_key addr=%0d got=%h exp=0000", a, v);
            end
        end
        @(negedge clk);
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || key_done !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset busy=%b key_done=%b exp=0/0", busy, key_done);
        end
        $display("test_reset done");
    endtask

    task automatic test_vector;
        logic [15:0] v;
        logic [15:0] exp_lo [4];
        int cyc, bcyc;
        exp_lo = '{16'h0100, 16'h0908, 16'h1110, 16'h1918};
        apply_start(KEY_STD);
        for (int a = 0; a < 4; a++) begin
            read_key(a, v);
            checks++;
            if (v !== exp_lo[a]) begin
                failures++; $display("FAIL vec_master addr=%0d got=%h exp=%h", a, v, exp_lo[a]);
            end
        end
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 28) begin
            failures++; $display("FAIL vec_latency got=%0d exp=28", cyc);
        end
        checks++;
        if (bcyc != 28) begin
            failures++; $display("FAIL vec_busy_cycles got=%0d exp=28", bcyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL vec_busy_after_done got=%b exp=0", busy);
        end
        read_key(4, v);
        checks++;
        if (v !== 16'h71C3) begin
            failures++; $display("FAIL vec_k4 got=%h exp=71c3", v);
        end
        $display("test_vector latency=%0d busy_cycles=%0d", cyc, bcyc);
    endtask

    task automatic test_full_schedule;
        logic [15:0] x, y, t;
        model_keys(KEY_STD);
        for (int a = 0; a < 32; a++) begin
            read_key(a, dut_k[a]);
            checks++;
            if (dut_k[a] !== exp_k[a]) begin
                failures++; $display("FAIL sched_key addr=%0d got=%h exp=%h", a, dut_k[a], exp_k[a]);
            end
        end
        x = 16'h6565; y = 16'h6877;
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2) ^ dut_k[i];
            y = t;
        end
        checks++;
        if ({x, y} !== 32'hC69B_E9BB) begin
            failures++; $display("FAIL sched_cipher got=%h exp=c69be9bb", {x, y});
        end
        $display("test_full_schedule cipher=%h", {x, y});
    endtask

    task automatic test_restart;
        logic [15:0] v;
        int cyc, bcyc;
        apply_start(KEY_STD);
        repeat (10) @(negedge clk);
        apply_start(64'h0);
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 28) begin
            failures++; $display("FAIL restart_latency got=%0d exp=28", cyc);
        end
        read_key(4, v);
        checks++;
        if (v !== 16'hFFFD) begin
            failures++; $display("FAIL restart_k4 got=%h exp=fffd", v);
        end
        read_key(5, v);
        checks++;
        if (v !== 16'h9FFD) begin
            failures++; $display("FAIL restart_k5 got=%h exp=9ffd", v);
        end
        model_keys(64'h0);
        read_key(31, v);
        checks++;
        if (v !== exp_k[31]) begin
            failures++; $display("FAIL restart_k31 got=%h exp=%h", v, exp_k[31]);
        end
        $display("test_restart latency=%0d", cyc);
    endtask

    task automatic test_reset_mid_gen;
        logic [15:0] v;
        int seen_done;
        apply_start(KEY_STD);
        repeat (6) @(negedge clk);
        rd_addr = 5'd0;
        #2;
        res_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || key_done !== 1'b0) begin
            failures++; $display("FAIL midreset_flags busy=%b key_done=%b exp=0/0", busy, key_done);
        end
        checks++;
        if (rd_key !== 16'h0) begin
            failures++; $display("FAIL midreset_rd_key got=%h exp=0000", rd_key);
        end
        @(negedge clk);
        res_n = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (key_done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++; $display("FAIL midreset_no_done got=%0d exp=0", seen_done);
        end
        read_key(7, v);
        checks++;
        if (v !== 16'h0) begin
            failures++; $display("FAIL midreset_k7 got=%h exp=0000", v);
        end
        $display("test_reset_mid_gen done");
    endtask

    task automatic test_hold;
        logic [15:0] v;
        int cyc, bcyc;
        apply_start(KEY_STD);
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 28) begin
            failures++; $display("FAIL hold_latency got=%0d exp=28", cyc);
        end
        repeat (100) @(negedge clk);
        model_keys(KEY_STD);
        for (int a = 31; a >= 0; a--) begin
            read_key(a, v);
            checks++;
            if (v !== exp_k[a]) begin
                failures++; $display("FAIL hold_key addr=%0d got=%h exp=%h", a, v, exp_k[a]);
            end
        end
        checks++;
        if (key_done !== 1'b1) begin
            failures++; $display("FAIL hold_key_done got=%b exp=1", key_done);
        end
        $display("test_hold done");
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        int cyc, bcyc;
        logic [63:0] key_c;
        key_c = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        start = 1'b1; key_in = 64'hAAAA_5555_AAAA_5555;
        @(negedge clk);
        key_in = 64'hFFFF_0000_1234_8765;
        @(negedge clk);
        key_in = key_c;
        @(negedge clk);
        start = 1'b0; key_in = '0;
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 28) begin
            failures++; $display("FAIL b2b_latency got=%0d exp=28", cyc);
        end
        model_keys(key_c);
        for (int a = 0; a < 32; a++) begin
            read_key(a, v);
            checks++;
            if (v !== exp_k[a]) begin
                failures++; $display("FAIL b2b_key addr=%0d got=%h exp=%h", a, v, exp_k[a]);
            end
        end
        $display("test_back_to_back latency=%0d", cyc);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_vector();
        test_full_schedule();
        test_restart();
        test_reset_mid_gen();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
